// File: rtl/geig_multi_data_handling.sv
// geig_multi_data_handling: N-channel Geiger pulse counter. Each window edge packs the
// timestamp and all channel counts into one record, held in a first-word-fall-through FIFO.
module geig_multi_data_handling #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned TS_WIDTH   = 24,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                                CLK_1KHZ,
  input  logic                                NSYSRESET,
  input  logic                                CLK_10HZ,
  input  logic [TS_WIDTH-1:0]                 TIMESTAMP,
  input  logic [N_CH-1:0]                     GSTREAM,
  input  logic                                RD_EN,
  output logic [TS_WIDTH+N_CH*CNT_WIDTH-1:0]  G_DATA_STACK,
  output logic                                DATA_VALID,
  output logic [$clog2(FIFO_DEPTH):0]         FIFO_COUNT,
  output logic                                OVERFLOW
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = TS_WIDTH + N_CH * CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [AW:0] CountFull = (AW + 1)'(FIFO_DEPTH);

  logic [N_CH-1:0] gs_sync1_q, gs_sync2_q, gs_prev_q, gs_edge;
  logic            win_sync1_q, win_sync2_q, win_prev_q, win_edge;

  logic [CNT_WIDTH-1:0] cnt_q [N_CH];
  logic [CNT_WIDTH-1:0] cnt_d [N_CH];
  logic [RW-1:0]        rec;

  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          empty, full, pop, wr_en;

  // Two-flop synchronisers plus a previous-value stage for rising-edge detection.
  always_ff @(posedge CLK_1KHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      gs_sync1_q  <= '0;
      gs_sync2_q  <= '0;
      gs_prev_q   <= '0;
      win_sync1_q <= 1'b0;
      win_sync2_q <= 1'b0;
      win_prev_q  <= 1'b0;
    end else begin
      gs_sync1_q  <= GSTREAM;
      gs_sync2_q  <= gs_sync1_q;
      gs_prev_q   <= gs_sync2_q;
      win_sync1_q <= CLK_10HZ;
      win_sync2_q <= win_sync1_q;
      win_prev_q  <= win_sync2_q;
    end
  end

  assign gs_edge  = gs_sync2_q & ~gs_prev_q;
  assign win_edge = win_sync2_q & ~win_prev_q;

  // Counter next state: a coincident pulse always lands in the new window.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (win_edge && MODE == 0) begin
        cnt_d[i] = CNT_WIDTH'(gs_edge[i]);
      end else if (gs_edge[i] && cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge CLK_1KHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Record built from pre-update counter values.
  always_comb begin
    rec = '0;
    rec[RW-1 -: TS_WIDTH] = TIMESTAMP;
    for (int i = 0; i < int'(N_CH); i++) rec[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);
  assign pop   = RD_EN & ~empty;
  // When full, a same-cycle pop frees the head slot, which is the slot being written.
  assign wr_en = win_edge & (~full | pop);

  // FIFO storage; contents are only visible through the empty-gated head output.
  always_ff @(posedge CLK_1KHZ) begin
    if (wr_en) mem_q[wr_ptr_q] <= rec;
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK_1KHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (win_edge && full && !pop) ovf_q <= 1'b1;
    end
  end

  // First-word-fall-through outputs.
  always_comb begin
    G_DATA_STACK = empty ? '0 : mem_q[rd_ptr_q];
    DATA_VALID   = ~empty;
    FIFO_COUNT   = count_q;
    OVERFLOW     = ovf_q;
  end

endmodule

// File: tb/tb_geig_multi_data_handling.sv
// Bench for geig_multi_data_handling: MODE=0 and MODE=1 instances share stimulus and are
// compared against a window-level model (pulse tallies per window, queue of records).
module tb_geig_multi_data_handling;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned TS_W  = 24;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = TS_W + N_CH * CW;

  logic          clk = 1'b0;
  logic          nrst;
  logic          clk10;
  logic [TS_W-1:0] ts;
  logic [N_CH-1:0] gs;
  logic          rd;
  logic [RW-1:0] data0, data1;
  logic          v0, v1, ov0, ov1;
  logic [2:0]    cnt0, cnt1;

  always #5 clk = ~clk;

  geig_multi_data_handling #(
    .N_CH(N_CH), .TS_WIDTH(TS_W), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .MODE(0)
  ) dut_m0 (
    .CLK_1KHZ(clk), .NSYSRESET(nrst), .CLK_10HZ(clk10), .TIMESTAMP(ts), .GSTREAM(gs),
    .RD_EN(rd), .G_DATA_STACK(data0), .DATA_VALID(v0), .FIFO_COUNT(cnt0), .OVERFLOW(ov0)
  );

  geig_multi_data_handling #(
    .N_CH(N_CH), .TS_WIDTH(TS_W), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .MODE(1)
  ) dut_m1 (
    .CLK_1KHZ(clk), .NSYSRESET(nrst), .CLK_10HZ(clk10), .TIMESTAMP(ts), .GSTREAM(gs),
    .RD_EN(rd), .G_DATA_STACK(data1), .DATA_VALID(v1), .FIFO_COUNT(cnt1), .OVERFLOW(ov1)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: records stored as saturated per-window and running-total counts.
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [CW-1:0]   a1, a0;  // per-window counts
    logic [CW-1:0]   b1, b0;  // running totals
  } rec_t;

  rec_t q[$];
  int   win[2];
  int   tot[2];
  bit   ovf;

  typedef struct {
    logic [TS_W-1:0] ts;
    int              n0, n1;
    logic [RW-1:0]   exp0, exp1;
  } vec_t;

  vec_t tbl[3];

  function automatic logic [CW-1:0] sat(int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic logic [RW-1:0] head(bit m1);
    if (q.size() == 0) return '0;
    return m1 ? {q[0].ts, q[0].b1, q[0].b0} : {q[0].ts, q[0].a1, q[0].a0};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_state(string tag);
    chk({tag, "/data_m0"}, 64'(data0), 64'(head(0)));
    chk({tag, "/data_m1"}, 64'(data1), 64'(head(1)));
    chk({tag, "/valid"}, 64'({v1, v0}), 64'({2{q.size() != 0}}));
    chk({tag, "/count"}, 64'({cnt1, cnt0}), 64'({2{3'(q.size())}}));
    chk({tag, "/overflow"}, 64'({ov1, ov0}), 64'({2{ovf}}));
  endtask

  task automatic model_reset();
    q.delete();
    win = '{0, 0};
    tot = '{0, 0};
    ovf = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean pulses, all channels in phase; both counts tallied into the open window.
  task automatic pulses(int n0, int n1, int hi, int lo);
    int m;
    m = (n0 > n1) ? n0 : n1;
    for (int k = 0; k < m; k++) begin
      gs = {k < n1, k < n0};
      cyc(hi);
      gs = '0;
      cyc(lo);
    end
    win[0] += n0; win[1] += n1;
    tot[0] += n0; tot[1] += n1;
  endtask

  // One window close; optional pulse on channel 0 in the same cycle and pop on the push edge.
  task automatic window(logic [TS_W-1:0] t, bit coinc, bit rd_on_push);
    rec_t r;
    ts = t;
    clk10 = 1'b1;
    if (coinc) gs[0] = 1'b1;
    cyc(2);
    if (rd_on_push) rd = 1'b1;
    clk10 = 1'b0;
    gs = '0;
    cyc(1);
    rd = 1'b0;
    cyc(2);
    r = '{ts: t, a1: sat(win[1]), a0: sat(win[0]), b1: sat(tot[1]), b0: sat(tot[0])};
    if (rd_on_push && q.size() != 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(r);
    else ovf = 1'b1;
    win = '{0, 0};
    if (coinc) begin
      win[0]++;
      tot[0]++;
    end
  endtask

  task automatic pop();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // Asynchronous assertion away from any clock edge, checked before the next edge.
  task automatic do_reset(string tag);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check_state(tag);
    gs = '0;
    clk10 = 1'b0;
    rd = 1'b0;
    @(negedge clk);
    cyc(2);
    nrst = 1'b1;
    cyc(2);
  endtask

  int m1exp[3];

  initial begin
    tbl[0] = '{ts: 24'h00ABCD, n0: 5,   n1: 3,
               exp0: {24'h00ABCD, 8'd3, 8'd5},  exp1: {24'h00ABCD, 8'd3, 8'd5}};
    tbl[1] = '{ts: 24'h000100, n0: 300, n1: 0,
               exp0: {24'h000100, 8'd0, 8'hFF}, exp1: {24'h000100, 8'd3, 8'hFF}};
    tbl[2] = '{ts: 24'h000200, n0: 2,   n1: 0,
               exp0: {24'h000200, 8'd0, 8'd2},  exp1: {24'h000200, 8'd3, 8'hFF}};
    m1exp = '{2, 5, 9};

    nrst = 1'b1; clk10 = 1'b0; ts = '0; gs = '0; rd = 1'b0;
    #1 nrst = 1'b0;
    model_reset();

    // Reset held while inputs toggle.
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      gs = 2'($urandom); clk10 = 1'($urandom); rd = 1'($urandom); ts = 24'($urandom);
      cyc(1);
      if (k % 4 == 3) check_state("reset_hold");
    end
    gs = '0; clk10 = 1'b0; rd = 1'b0;
    cyc(2);
    nrst = 1'b1;
    cyc(2);
    check_state("reset_release");

    // Table-driven windows: basic, saturation, recovery after saturation.
    for (int i = 0; i < 3; i++) begin
      pulses(tbl[i].n0, tbl[i].n1, 2, 2);
      window(tbl[i].ts, 1'b0, 1'b0);
      chk($sformatf("tbl%0d/rec_m0", i), 64'(data0), 64'(tbl[i].exp0));
      chk($sformatf("tbl%0d/rec_m1", i), 64'(data1), 64'(tbl[i].exp1));
      check_state($sformatf("tbl%0d/pushed", i));
      pop();
      chk($sformatf("tbl%0d/valid_after_pop", i), 64'(v0), 64'(0));
    end

    // Pulse coincident with window edge belongs to the next window.
    window(24'h000310, 1'b1, 1'b0);
    chk("coinc/closed_ch0", 64'(data0[7:0]), 64'(0));
    check_state("coinc/closed");
    pop();
    cyc(2);
    window(24'h000320, 1'b0, 1'b0);
    chk("coinc/next_ch0", 64'(data0[7:0]), 64'(1));
    check_state("coinc/next");
    pop();

    // Overflow and ordering.
    for (int k = 1; k <= 5; k++) begin
      pulses(k, 0, 2, 2);
      window(24'h000400 + 24'(k), 1'b0, 1'b0);
    end
    chk("ovf/count", 64'(cnt0), 64'(4));
    chk("ovf/flag", 64'(ov0), 64'(1));
    check_state("ovf/full");
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf/order%0d", k), 64'(data0[7:0]), 64'(k));
      pop();
    end
    check_state("ovf/drained");
    pop();  // read while empty
    check_state("ovf/empty_read");

    // Push and pop together while full.
    do_reset("pp/reset");
    for (int k = 1; k <= 4; k++) begin
      pulses(k, 0, 2, 2);
      window(24'h000500 + 24'(k), 1'b0, 1'b0);
    end
    pulses(5, 0, 2, 2);
    window(24'h000505, 1'b0, 1'b1);
    chk("pp/count", 64'(cnt0), 64'(4));
    chk("pp/no_ovf", 64'(ov0), 64'(0));
    check_state("pp/after");
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp/order%0d", k), 64'(data0[7:0]), 64'(k));
      pop();
    end

    // Running totals, then reset partway through a window.
    do_reset("m1/reset");
    for (int k = 2; k <= 4; k++) begin
      pulses(k, 0, 2, 2);
      window(24'h000600 + 24'(k), 1'b0, 1'b0);
    end
    check_state("m1/three");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("m1/total%0d", k), 64'(data1[7:0]), 64'(m1exp[k]));
      pop();
    end
    pulses(3, 2, 2, 2);
    do_reset("midwin/reset");
    pulses(1, 0, 2, 2);
    window(24'h000700, 1'b0, 1'b0);
    chk("midwin/m0", 64'(data0[7:0]), 64'(1));
    chk("midwin/m1", 64'(data1[7:0]), 64'(1));
    check_state("midwin/rec");
    pop();

    // Randomised windows and reads against the model.
    for (int w = 0; w < 24; w++) begin
      pulses(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
             int'($urandom_range(2, 3)), int'($urandom_range(2, 3)));
      window(24'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      check_state($sformatf("rnd%0d/win", w));
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
        pop();
        check_state($sformatf("rnd%0d/pop", w));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/geig_multi_data_handling.md
# geig_multi_data_handling

Parametrised successor to the single-channel Geiger data handler. It counts rising edges on N_CH Geiger pulse streams in the CLK_1KHZ domain. On every CLK_10HZ window edge it packs the current TIMESTAMP and all channel counts into one record and pushes it into an internal first-word-fall-through FIFO. The downlink/telemetry packer drains the FIFO at its own pace through a valid/read handshake.

## Interface
- N_CH, 2, number of Geiger channels (≥1)
- TS_WIDTH, 24, timestamp width
- CNT_WIDTH, 16, per-channel counter width
- FIFO_DEPTH, 8, record FIFO depth (power of 2, ≥2)
- MODE, 0, 0 = counters clear each window; 1 = running totals, never cleared except by reset

Ports:
- CLK_1KHZ  in  1  system clock, all logic on rising edge
- NSYSRESET  in  1  asynchronous, active-low reset
- CLK_10HZ  in  1  window clock, treated as asynchronous data, 2-flop synchronised
- TIMESTAMP  in  TS_WIDTH  mission time, already in CLK_1KHZ domain, sampled unsynchronised
- GSTREAM  in  N_CH  Geiger pulse streams, asynchronous, 2-flop synchronised per bit
- RD_EN  in  1  pop request from consumer
- G_DATA_STACK  out  TS_WIDTH+N_CH*CNT_WIDTH  FIFO head record: {TIMESTAMP, cnt[N_CH-1], …, cnt[0]}
- DATA_VALID  out  1  FIFO non-empty; G_DATA_STACK is valid
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  records held
- OVERFLOW  out  1  sticky: a record was dropped

## Operation
- Input conditioning: each GSTREAM bit and CLK_10HZ pass through sync1 → sync2 → prev. edge = sync2 & ~prev.
- Counters: on a channel edge, cnt[i] increments. It saturates at all-ones and never wraps.
- Window edge (CLK_10HZ edge):
  - Record {TIMESTAMP, cnt[N_CH-1..0]} is formed from the counter values before this cycle's update.
  - MODE=0: cnt[i] loads 1 if channel i has an edge in the same cycle, else 0.
  - MODE=1: cnt[i] continues accumulating (saturating), including a same-cycle edge.
- A GSTREAM edge coincident with a window edge belongs to the new window, never the closed one.
- FIFO: first-word-fall-through. G_DATA_STACK always shows the oldest record, or all zeros when empty.
- Pop: occurs when RD_EN & DATA_VALID. RD_EN while empty is ignored with no side effects.
- Push while full, no pop in the same cycle: record is dropped, FIFO contents unchanged, OVERFLOW set.
- Push and pop in the same cycle: both occur and FIFO_COUNT is unchanged. This applies when full too, with no overflow.
- OVERFLOW clears only on reset.
- Reset (async assert, any time including mid-window or mid-read):
  - All synchronisers, counters, FIFO pointers and OVERFLOW clear.
  - G_DATA_STACK=0, DATA_VALID=0, FIFO_COUNT=0.
  - The first window after reset closes on the first CLK_10HZ rising edge seen after release. sync/prev registers are reset to 0, so a CLK_10HZ already high at release counts as an edge.

## Timing
- Async input rising edge to counter update: 3 CLK_1KHZ edges (sync1, sync2, counter).
- Minimum pulse: high ≥2 periods and low ≥2 periods for a guaranteed count. Shorter pulses may be missed, but are never double-counted.
- CLK_10HZ rising edge to push: 3 CLK_1KHZ edges.
- DATA_VALID rises, G_DATA_STACK shows the record and FIFO_COUNT increments, all on the same edge that pushes into an empty FIFO.
- Pop: G_DATA_STACK advances to the next record (or zeros) on the edge where RD_EN & DATA_VALID is sampled. Zero-latency throughput: one pop per cycle.
- Recorded TIMESTAMP is the value present at the push edge.

## Test plan
Bench parameters unless noted: N_CH=2, CNT_WIDTH=8, FIFO_DEPTH=4, MODE=0.

1. Reset: hold NSYSRESET=0 with toggling inputs → G_DATA_STACK=0, DATA_VALID=0, FIFO_COUNT=0, OVERFLOW=0.
2. Basic window: 5 clean pulses on GSTREAM[0] and 3 on GSTREAM[1], then CLK_10HZ rise with TIMESTAMP=24'h00ABCD.
   - G_DATA_STACK={24'h00ABCD, 8'd3, 8'd5}, DATA_VALID=1, FIFO_COUNT=1.
   - Pulse RD_EN → DATA_VALID=0.
3. Saturation: 300 pulses on channel 0 in one window → channel-0 field = 8'hFF. Next window with 2 pulses → 8'd2.
4. Coincidence: GSTREAM[0] synchronised edge in the same cycle as the window edge, otherwise idle.
   - Record channel 0 = 0.
   - Next window, with no more pulses, record channel 0 = 1.
5. Overflow and ordering: 5 windows with counts 1..5 on channel 0 and no reads.
   - FIFO_COUNT=4, OVERFLOW=1.
   - Successive pops yield 1, 2, 3, 4, then DATA_VALID=0.
   - Repeat with FIFO full and RD_EN asserted on the push cycle → no overflow, FIFO_COUNT stays 4.
6. MODE=1 and reset mid-operation: windows with 2, 3, 4 pulses → records 2, 5, 9. Assert NSYSRESET mid-window → all outputs 0; next record counts only post-reset pulses.
